// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: buffers operand pairs and steps them through a multicycle fpu; define FPU_SEQ_LOOP_EN for continuous looping with a stop input
module fpu_op_sequencer #(
    parameter int DEPTH         = 8,
    parameter int SETTLE_CYCLES = 100,
    parameter int CNT_W         = 16
) (
    input  logic                     clock100KHz,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [31:0]              wr_a,
    input  logic [31:0]              wr_b,
    output logic                     wr_ready,
    input  logic                     start,
`ifdef FPU_SEQ_LOOP_EN
    input  logic                     stop,
`endif
    output logic                     busy,
    output logic [31:0]              op_A_out,
    output logic [31:0]              op_B_out,
    input  logic [31:0]              fpu_data_in,
    input  logic [3:0]               fpu_status_in,
    output logic                     res_valid,
    output logic [31:0]              res_data,
    output logic [3:0]               res_status,
    output logic [$clog2(DEPTH)-1:0] res_idx,
    output logic [CNT_W-1:0]         cnt_exact,
    output logic [CNT_W-1:0]         cnt_ovf,
    output logic [CNT_W-1:0]         cnt_unf,
    output logic [CNT_W-1:0]         cnt_inexact,
    output logic                     done
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_CAPTURE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0]      r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [IW-1:0]    r_wr_ptr;
    logic [IW-1:0]    r_rd_ptr;
    logic [TW-1:0]    r_timer;
    logic             r_wr_ready;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [31:0]      r_res_data;
    logic [3:0]       r_res_status;
    logic [IW-1:0]    r_res_idx;
    logic             r_res_valid;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt [4];
    logic             w_wr_acc;
    logic             w_last;
    logic             w_capture;
    logic             w_exit;
`ifdef FPU_SEQ_LOOP_EN
    logic             r_stop;
    logic             w_stop;

    assign w_stop = r_stop | stop;
`endif

    assign w_wr_acc  = wr_en & r_wr_ready;
    assign w_last    = {1'b0, r_rd_ptr} == r_count - CW'(1);
    assign w_capture = r_state == S_CAPTURE;
    assign w_exit    = w_capture & (w_state_nxt == S_IDLE);
    assign w_count_nxt = w_exit ? '0 : r_count + CW'(w_wr_acc);

    assign wr_ready    = r_wr_ready;
    assign busy        = r_state != S_IDLE;
    assign op_A_out    = r_op_a;
    assign op_B_out    = r_op_b;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_status  = r_res_status;
    assign res_idx     = r_res_idx;
    assign done        = r_done;
    assign cnt_exact   = r_cnt[0];
    assign cnt_ovf     = r_cnt[1];
    assign cnt_unf     = r_cnt[2];
    assign cnt_inexact = r_cnt[3];

    // next-state: load, settle, capture each pair; leave after the last pair (or on stop when looping)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    w_state_nxt = (start && r_count != '0) ? S_LOAD : S_IDLE;
            S_LOAD:    w_state_nxt = S_WAIT;
            S_WAIT:    w_state_nxt = (r_timer == '0) ? S_CAPTURE : S_WAIT;
`ifdef FPU_SEQ_LOOP_EN
            S_CAPTURE: w_state_nxt = w_stop ? S_IDLE : S_LOAD;
`else
            S_CAPTURE: w_state_nxt = w_last ? S_IDLE : S_LOAD;
`endif
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // buffer bookkeeping: fill pointer, occupancy, read pointer and write readiness
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ready <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_wr_ptr   <= w_exit ? '0 : (w_wr_acc ? r_wr_ptr + IW'(1) : r_wr_ptr);
            r_wr_ready <= (w_state_nxt == S_IDLE) && (w_count_nxt != CW'(DEPTH));
            if (r_state == S_IDLE)
                r_rd_ptr <= '0;
            else if (w_capture && w_state_nxt == S_LOAD)
                r_rd_ptr <= w_last ? '0 : r_rd_ptr + IW'(1);
        end
    end

    // operand storage; contents survive reset since occupancy gates every read
    always_ff @(posedge clock100KHz) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= {wr_a, wr_b};
    end

    // drive operands only in LOAD and count down the settle time
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_timer <= '0;
        end else if (r_state == S_LOAD) begin
            {r_op_a, r_op_b} <= r_mem[r_rd_ptr];
            r_timer          <= TW'(SETTLE_CYCLES - 1);
        end else if (r_state == S_WAIT && r_timer != '0) begin
            r_timer <= r_timer - TW'(1);
        end
    end

    // result capture with one-cycle valid and done pulses
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            r_res_data   <= '0;
            r_res_status <= '0;
            r_res_idx    <= '0;
            r_res_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_res_valid <= w_capture;
            r_done      <= w_capture & w_last;
            if (w_capture) begin
                r_res_data   <= fpu_data_in;
                r_res_status <= fpu_status_in;
                r_res_idx    <= r_rd_ptr;
            end
        end
    end

    // saturating event counters, one per status bit, all bumped together for multi-hot status
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < 4; i++)
                if (fpu_status_in[i] && r_cnt[i] != {CNT_W{1'b1}}) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
    end

`ifdef FPU_SEQ_LOOP_EN
    // hold a stop request until the sequencer returns to idle
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset)                         r_stop <= 1'b0;
        else if (r_state == S_IDLE || w_exit) r_stop <= 1'b0;
        else if (stop)                     r_stop <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: random and directed checks of fpu_op_sequencer against a queue-based reference model
module tb_fpu_op_sequencer;
    localparam int DEPTH  = 8;
    localparam int SETTLE = 5;
    localparam int CNT_W  = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int PER    = SETTLE + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [31:0]       wr_a = '0;
    logic [31:0]       wr_b = '0;
    logic              start = 1'b0;
`ifdef FPU_SEQ_LOOP_EN
    logic              stop = 1'b0;
`endif
    logic              wr_ready, busy, res_valid, done;
    logic [31:0]       op_A_out, op_B_out, fpu_data_in, res_data;
    logic [3:0]        fpu_status_in, res_status;
    logic [2:0]        res_idx;
    logic [CNT_W-1:0]  cnt_exact, cnt_ovf, cnt_unf, cnt_inexact;

    logic [63:0]       m_q [$];
    int                m_cnt [4];
    int                total = 0;
    int                bad = 0;

    fpu_op_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
        .clock100KHz(clk), .reset(rst), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
        .wr_ready(wr_ready), .start(start),
`ifdef FPU_SEQ_LOOP_EN
        .stop(stop),
`endif
        .busy(busy), .op_A_out(op_A_out), .op_B_out(op_B_out),
        .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in),
        .res_valid(res_valid), .res_data(res_data), .res_status(res_status), .res_idx(res_idx),
        .cnt_exact(cnt_exact), .cnt_ovf(cnt_ovf), .cnt_unf(cnt_unf), .cnt_inexact(cnt_inexact),
        .done(done)
    );

    always #5 clk = ~clk;

    // stand-in for the fpu: any fixed function of the presented operands
    function automatic logic [31:0] f_res(input logic [31:0] a, input logic [31:0] b);
        return a + {b[15:0], b[31:16]};
    endfunction
    function automatic logic [3:0] f_st(input logic [31:0] a, input logic [31:0] b);
        return a[3:0] ^ b[7:4];
    endfunction

    assign fpu_data_in   = f_res(op_A_out, op_B_out);
    assign fpu_status_in = f_st(op_A_out, op_B_out);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*CNT_W-1:0] exp_cnt();
        return {CNT_W'(m_cnt[3]), CNT_W'(m_cnt[2]), CNT_W'(m_cnt[1]), CNT_W'(m_cnt[0])};
    endfunction

    task automatic model_capture(input logic [63:0] p);
        logic [3:0] s;
        s = f_st(p[63:32], p[31:0]);
        for (int i = 0; i < 4; i++) if (s[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    endtask

    task automatic check_result(input logic [63:0] p, input int idx, input int t, input int t_exp);
        chk("res_time", 64'(t), 64'(t_exp));
        chk("res_idx", 64'(res_idx), 64'(idx));
        chk("res_data", 64'(res_data), 64'(f_res(p[63:32], p[31:0])));
        chk("res_status", 64'(res_status), 64'(f_st(p[63:32], p[31:0])));
        chk("op_held", {op_A_out, op_B_out}, p);
        model_capture(p);
        chk("counters", 64'({cnt_inexact, cnt_unf, cnt_ovf, cnt_exact}), 64'(exp_cnt()));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] b);
        chk("wr_ready", 64'(wr_ready), 64'(m_q.size() < DEPTH));
        wr_en = 1'b1; wr_a = a; wr_b = b;
        @(negedge clk);
        wr_en = 1'b0;
        if (m_q.size() < DEPTH) m_q.push_back({a, b});
    endtask

    task automatic run();
        int n, got, dones, t;
        n = m_q.size(); got = 0; dones = 0; t = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", 64'(busy), 64'(n > 0));
        while (t < n * PER + 4) begin
            if (done) dones++;
            if (res_valid) begin
                if (got < n) begin
                    check_result(m_q[got], got, t, (got + 1) * PER);
                    chk("done_pulse", 64'(done), 64'(got == n - 1));
                end else chk("extra_valid", 64'(1), 64'(0));
                got++;
            end
            @(negedge clk);
            t++;
        end
        chk("valid_count", 64'(got), 64'(n));
        chk("done_count", 64'(dones), 64'(n > 0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_wr_ready", 64'(wr_ready), 64'(1));
        m_q.delete();
    endtask

    initial begin
        int n;
        int sb;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", 64'({wr_ready, busy, res_valid, done, op_A_out}), 64'(0));
        rst = 1'b0;
        chk("rst_wr_ready_low", 64'(wr_ready), 64'(0));
        @(negedge clk);
        chk("rst_wr_ready_up", 64'(wr_ready), 64'(1));

        wr(32'h3E000000, 32'h3E000000);
        run();

        wr(32'h3E000000, 32'hBE000000);
        wr(32'hC0000000, 32'hC0000000);
        wr(32'h42000000, 32'hC0000000);
        run();

        for (int i = 0; i < DEPTH + 1; i++) wr($urandom, $urandom);
        chk("full_wr_ready", 64'(wr_ready), 64'(0));
        run();

        wr(32'h7FFFFFFF, 32'h7FFFFFFF);
        run();

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb = 0;
        repeat (PER + 2) begin
            if (busy || done || res_valid) sb = 1;
            @(negedge clk);
        end
        chk("empty_start", 64'(sb), 64'(0));

        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, DEPTH + 2);
            for (int i = 0; i < n; i++) wr($urandom, $urandom);
            run();
        end

        wr($urandom, $urandom);
        wr($urandom, $urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_outputs", 64'({res_valid, busy, done, op_A_out}), 64'(0));
        chk("abort_counters", 64'({cnt_inexact, cnt_unf, cnt_ovf, cnt_exact}), 64'(0));
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_q.delete();
        @(negedge clk);
        chk("abort_hold", 64'({res_valid, done, wr_ready}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("abort_wr_ready", 64'(wr_ready), 64'(1));

        wr(32'h3E000000, 32'h3E000000);
        run();

`ifdef FPU_SEQ_LOOP_EN
        begin
            int got, dones;
            got = 0; dones = 0;
            wr($urandom, $urandom);
            wr($urandom, $urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int t = 0; t < 4 * PER + 4; t++) begin
                stop = (t == 2 * PER + 2);
                if (done) dones++;
                if (res_valid) begin
                    if (got < 3) check_result(m_q[got % 2], got % 2, t, (got + 1) * PER);
                    got++;
                end
                @(negedge clk);
            end
            stop = 1'b0;
            chk("loop_valids", 64'(got), 64'(3));
            chk("loop_dones", 64'(dones), 64'(1));
            chk("loop_idle", 64'(busy), 64'(0));
            m_q.delete();
            for (int i = 0; i < DEPTH - 1; i++) wr($urandom, $urandom);
            run();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
